// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath.
// Holds the default window geometry, the pixel type and the window array
// type that both the window generator and the conv block use, plus a helper
// for sizing position counters.
package cnn_pkg;

  localparam int CNN_SIZE      = 3;
  localparam int CNN_WIDTH_BIT = 8;

  typedef logic [CNN_WIDTH_BIT-1:0] pixel_t;

  // [r][c]: r=0 is the oldest row, c=0 the leftmost column.
  typedef pixel_t [CNN_SIZE-1:0][CNN_SIZE-1:0] window_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage, IMG_W entries deep.
// Ports:
//   clock - rising-edge clock
//   we    - write din at addr on this edge
//   addr  - column address (shared by read and write)
//   din   - value to store
//   dout  - combinational read of the value currently stored at addr
// Contents are deliberately not reset: rows are refilled before they are used.
module conv_line_buffer #(
  parameter int IMG_W     = 8,
  parameter int WIDTH_BIT = 8,
  parameter int AW        = 3
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WIDTH_BIT-1:0] din,
  output logic [WIDTH_BIT-1:0] dout
);

  logic [WIDTH_BIT-1:0] mem [IMG_W];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
  end

  // Old value is read in the same cycle it is overwritten.
  assign dout = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding SIZE x SIZE window generator for a raster-order pixel stream.
// Buffers SIZE-1 rows and emits every fully populated window (no padding).
// Ports:
//   clock      - rising-edge clock
//   nreset     - synchronous, active-high reset
//   pix_in     - incoming pixel, raster order
//   pix_valid  - pix_in valid
//   pix_ready  - pixel accepted this cycle when pix_valid is also high
//   winMatrixO - current window [r][c], r=0 oldest row, c=0 leftmost column
//   win_valid  - winMatrixO holds a window to be taken
//   win_ready  - consumer takes the window this cycle
//   win_last   - final window of the frame (qualified by win_valid)
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high; an offered window and its flags stay bit-stable until taken.
// There is a single output stage, so pix_ready = !win_valid || win_ready.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int SIZE      = CNN_SIZE,
  parameter int WIDTH_BIT = CNN_WIDTH_BIT,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                                        clock,
  input  logic                                        nreset,
  input  logic [WIDTH_BIT-1:0]                        pix_in,
  input  logic                                        pix_valid,
  output logic                                        pix_ready,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]    winMatrixO,
  output logic                                        win_valid,
  input  logic                                        win_ready,
  output logic                                        win_last
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(SIZE - 1);

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic                 accept;
  logic                 consume;
  logic                 emit;
  logic                 col_end;
  logic                 frame_end;
  logic [WIDTH_BIT-1:0] lb_rd   [SIZE-1];
  logic [WIDTH_BIT-1:0] new_col [SIZE];

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign consume   = win_valid && win_ready;
  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end && (row == ROW_LAST);
  assign emit      = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);

  // Line buffers form a vertical shift chain per column: each accepted pixel
  // pushes the column's history up one row, the newest row taking pix_in.
  for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
    if (k < SIZE - 2) begin : g_mid
      conv_line_buffer #(.IMG_W(IMG_W), .WIDTH_BIT(WIDTH_BIT), .AW(COL_W)) u_lb (
        .clock (clock),
        .we    (accept),
        .addr  (col),
        .din   (lb_rd[k+1]),
        .dout  (lb_rd[k])
      );
    end else begin : g_top
      conv_line_buffer #(.IMG_W(IMG_W), .WIDTH_BIT(WIDTH_BIT), .AW(COL_W)) u_lb (
        .clock (clock),
        .we    (accept),
        .addr  (col),
        .din   (pix_in),
        .dout  (lb_rd[k])
      );
    end
    assign new_col[k] = lb_rd[k];
  end
  assign new_col[SIZE-1] = pix_in;

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clock) begin
    if (nreset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window shifts on every accept so the leftmost columns are already primed
  // when the first emitting column of a row arrives.
  always_ff @(posedge clock) begin
    if (nreset) begin
      winMatrixO <= '0;
    end else if (accept) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE - 1; c++) begin
          winMatrixO[r][c] <= winMatrixO[r][c+1];
        end
        winMatrixO[r][SIZE-1] <= new_col[r];
      end
    end
  end

  // An emitting accept wins over a plain consume: the new window replaces the
  // one being taken in the same cycle.
  always_ff @(posedge clock) begin
    if (nreset) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_last  <= frame_end;
    end else if (consume) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: drives row*8+col pixel frames, models each
// expected window from the pixel coordinates and checks every window taken,
// every stalled cycle and the reset state.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int SIZE  = CNN_SIZE;
  localparam int WB    = CNN_WIDTH_BIT;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int EXP_W = SIZE * SIZE * WB + 1;

  logic    clock = 1'b0;
  logic    nreset;
  pixel_t  pix_in;
  logic    pix_valid;
  logic    pix_ready;
  window_t win_mat;
  logic    win_valid;
  logic    win_ready;
  logic    win_last;

  conv_window_gen #(.SIZE(SIZE), .WIDTH_BIT(WB), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .winMatrixO (win_mat),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_last   (win_last)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_push;
  bit emit_prev;
  int br, bc;
  int acc_cnt, cons_cnt, last_cnt;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Window whose bottom-right pixel is (r, c), with its frame-end flag on top.
  function automatic logic [EXP_W-1:0] model_win(input int r, input int c);
    window_t w;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        w[i][j] = pixel_t'((r - SIZE + 1 + i) * IMG_W + (c - SIZE + 1 + j));
    return {(r == IMG_H - 1 && c == IMG_W - 1), w};
  endfunction

  // Called at the falling edge: observes what the next rising edge will do.
  task automatic sample();
    logic [EXP_W-1:0] got;
    got = {win_last, win_mat};
    if (emit_prev) begin
      check_val("latency_valid", win_valid, 1'b1);
      check_val("latency_win", got, last_push);
    end
    if (win_valid) begin
      check_val("window_expected", exp_q.size() != 0, 1'b1);
      if (win_ready) begin
        cons_cnt++;
        if (win_last) last_cnt++;
        if (exp_q.size() != 0) check_val("window", got, exp_q.pop_front());
      end else begin
        check_val("stall_ready", pix_ready, 1'b0);
        if (exp_q.size() != 0) check_val("stall_hold", got, exp_q[0]);
      end
    end else begin
      check_val("idle_ready", pix_ready, 1'b1);
    end
    if (pix_valid && pix_ready) begin
      acc_cnt++;
      emit_prev = (br >= SIZE - 1) && (bc >= SIZE - 1);
      if (emit_prev) begin
        last_push = model_win(br, bc);
        exp_q.push_back(last_push);
      end
      if (bc == IMG_W - 1) begin
        bc = 0;
        br = (br == IMG_H - 1) ? 0 : br + 1;
      end else begin
        bc++;
      end
    end else begin
      emit_prev = 1'b0;
    end
  endtask

  task automatic do_reset();
    nreset    = 1'b1;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b0;
    br = 0;
    bc = 0;
    emit_prev = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_val("reset_valid", win_valid, 1'b0);
    check_val("reset_last", win_last, 1'b0);
    check_val("reset_win", win_mat, '0);
    @(posedge clock); #1;
  endtask

  // driver: feed n pixels with random bubbles/readiness, optional 5-cycle
  // stall once stall_at windows have been taken, then drain the output.
  task automatic run_pixels(input int n, input int vpct, input int rpct, input int stall_at);
    int target;
    int stall_left;
    bit stall_done;
    int cyc;
    target     = acc_cnt + n;
    stall_left = 0;
    stall_done = (stall_at < 0);
    cyc        = 0;
    while (acc_cnt < target && cyc < 5000) begin
      pix_valid = ($urandom_range(0, 99) < vpct);
      pix_in    = pixel_t'(br * IMG_W + bc);
      if (!stall_done && cons_cnt >= stall_at && win_valid) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = ($urandom_range(0, 99) < rpct);
      end
      @(negedge clock);
      sample();
      @(posedge clock); #1;
      cyc++;
    end
    check_val("feed_done", acc_cnt, target);
    pix_valid = 1'b0;
    win_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || win_valid) && cyc < 200) begin
      @(negedge clock);
      sample();
      @(posedge clock); #1;
      cyc++;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    nreset    = 1'b1;
    pix_valid = 1'b0;
    pix_in    = '0;
    win_ready = 1'b0;
    acc_cnt   = 0;
    cons_cnt  = 0;
    last_cnt  = 0;
    br        = 0;
    bc        = 0;
    emit_prev = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // basic stream
    cons_cnt = 0; last_cnt = 0;
    run_pixels(64, 100, 100, -1);
    check_val("basic_count", cons_cnt, 36);
    check_val("basic_last", last_cnt, 1);

    // backpressure: 5-cycle stall while a window is offered
    cons_cnt = 0; last_cnt = 0;
    run_pixels(64, 100, 100, 10);
    check_val("stall_count", cons_cnt, 36);
    check_val("stall_last", last_cnt, 1);

    // random bubbles and readiness
    cons_cnt = 0; last_cnt = 0;
    run_pixels(64, 70, 60, -1);
    check_val("random_count", cons_cnt, 36);
    check_val("random_last", last_cnt, 1);

    // two frames back to back
    cons_cnt = 0; last_cnt = 0;
    run_pixels(128, 100, 100, -1);
    check_val("b2b_count", cons_cnt, 72);
    check_val("b2b_last", last_cnt, 2);

    // reset mid-frame after 30 pixels, then a fresh frame
    cons_cnt = 0; last_cnt = 0;
    run_pixels(30, 100, 100, -1);
    check_val("partial_count", cons_cnt, 10);
    do_reset();
    cons_cnt = 0; last_cnt = 0;
    run_pixels(64, 80, 70, 20);
    check_val("post_reset_count", cons_cnt, 36);
    check_val("post_reset_last", last_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming front end for the 3x3 convolution datapath.
- Accepts a raster-order pixel stream (one pixel per handshake) and buffers SIZE-1 image rows.
- Emits every fully-populated SIZE x SIZE window ("valid" convolution, no padding) in the array shape the conv block consumes.
- Acts as the producer/driver of the conv block's input matrix.

Parameters:
- SIZE, 3, window edge length (rows and columns).
- WIDTH_BIT, 8, pixel width in bits.
- IMG_W, 8, image width in pixels (must be >= SIZE).
- IMG_H, 8, image height in pixels (must be >= SIZE).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- nreset  input  1  reset; one clock; reset is synchronous and active-high.
- pix_in  input  WIDTH_BIT  incoming pixel, raster order (row-major, col 0 first).
- pix_valid  input  1  pix_in valid.
- pix_ready  output  1  block can accept pix_in this cycle.
- winMatrixO  output  [WIDTH_BIT-1:0] x [SIZE-1:0][SIZE-1:0]  current window; [r][c], r=0 oldest row, c=0 leftmost column.
- win_valid  output  1  winMatrixO holds a valid window.
- win_ready  input  1  consumer takes window this cycle.
- win_last  output  1  qualifies the final window of a frame (meaningful only with win_valid).

Behaviour:
- Accept: pix_valid && pix_ready. Consume: win_valid && win_ready.
- pix_ready = !win_valid || win_ready (combinational; single output stage, no skid).
- Position counters:
  - col counts 0..IMG_W-1; row counts 0..IMG_H-1.
  - Both advance only on accept.
  - col wraps to 0 and row increments when col==IMG_W-1.
  - At (IMG_H-1, IMG_W-1), both wrap to 0; the next frame starts with no idle cycle.
- Line buffers: SIZE-1 rows of IMG_W entries each. On accept at column col:
  - lb[k][col] <= lb[k+1][col] for k < SIZE-2.
  - lb[SIZE-2][col] <= pix_in.
- Window register (this is winMatrixO). On accept:
  - Every row shifts left one column.
  - New rightmost column: win[r][SIZE-1] <= lb[r][col] for r < SIZE-1, and win[SIZE-1][SIZE-1] <= pix_in.
  - The window shifts on every accept, including non-emitting positions.
- Emission:
  - On accept with row >= SIZE-1 && col >= SIZE-1, win_valid <= 1 next cycle.
  - win_last <= (row==IMG_H-1 && col==IMG_W-1).
  - Latency: window is visible 1 cycle after the accept of its bottom-right pixel.
- Clearing: on consume with no emitting accept in the same cycle, win_valid <= 0 and win_last <= 0.
- Simultaneous consume + accept: the new window replaces the old one; win_valid follows the new position.
- Stall: win_valid && !win_ready means pix_ready=0, and winMatrixO, win_valid and win_last are held bit-stable.
- Per-frame count: exactly (IMG_W-SIZE+1)*(IMG_H-SIZE+1) windows.
- Row-boundary columns: columns < SIZE-1 carry stale data from the previous row but are never emitted.
- Reset (any time, including mid-frame):
  - row, col, win_valid and win_last are cleared to 0, and winMatrixO is cleared to all zeros.
  - Line buffers are not reset; they are refilled by rows 0..SIZE-2 before any emission.
- Counter widths: $clog2(IMG_W) for col and $clog2(IMG_H) for row, minimum 1 bit each.
- No arithmetic on pixel values; data is passed through unmodified.

Decomposition:
- Package cnn_pkg holds:
  - Default constants CNN_SIZE=3 and CNN_WIDTH_BIT=8.
  - typedef pixel_t (logic [WIDTH_BIT-1:0]).
  - A window array typedef shared with the conv block.
- One sub-module, conv_line_buffer:
  - Single-row IMG_W-deep storage, addressed by col, with write enable.
  - Combinational read of the old value at col.
  - Instantiated SIZE-1 times via generate.
- Counters, window register and handshake stay in the top module.

Test Plan:
- Pixel values below are row*8+col; defaults SIZE=3, IMG_W=IMG_H=8.
- Basic stream, win_ready=1, continuous pix_valid:
  - The cycle after pixel 18 is accepted, win_valid=1 with winMatrixO={{0,1,2},{8,9,10},{16,17,18}}.
  - Exactly 36 windows per frame.
- Frame end: the 36th window is {{45,46,47},{53,54,55},{61,62,63}} with win_last=1; win_last=0 on the other 35.
- Backpressure: hold win_ready=0 for 5 cycles while win_valid=1.
  - pix_ready=0 throughout; winMatrixO, win_valid and win_last are unchanged.
  - After release, the sequence continues with no window lost or duplicated.
- Random pix_valid bubbles and random win_ready: the window sequence is identical to the basic-stream reference, order preserved, 36 windows.
- Back-to-back frames with no gap: the second frame's first window is {{0,1,2},{8,9,10},{16,17,18}}, with no window straddling the frame boundary.
- Reset mid-frame: assert nreset for 1 cycle after 30 pixels.
  - The next cycle shows win_valid=0, win_last=0 and winMatrixO all zero.
  - A fresh 64-pixel frame then produces the correct 36 windows.
